seq_alu: RTL

Clocked, parametrised successor to the combinational `sum` adder. It computes add, subtract, carry-chained and logic operations on `OP_SIZE`-bit operands. It processes `SLICE` bits per clock, LSB first, and holds the result and a persistent CVNZ condition code register between operations. It sits in the datapath as the shared arithmetic unit, with a start/busy/done handshake to the sequencer.

---
 rtl/seq_alu.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential slice-serial ALU: ADD/ADC/SUB/SBC/CMP (+ AND/OR/XOR when
// SEQ_ALU_LOGIC_OPS_EN is defined) with a persistent CVNZ condition code register.
module seq_alu #(
  parameter int OP_SIZE = 8,
  parameter int SLICE   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [OP_SIZE-1:0] A,
  input  logic [OP_SIZE-1:0] B,
  output logic [OP_SIZE-1:0] R,
  output logic [3:0]         CCR,
  output logic               busy,
  output logic               done
);

  // state  | meaning
  // IDLE   | waiting for start; operands and carry-in latched on accept
  // CALC   | one SLICE-bit slice per cycle, LSB first, into res_sh
  // FLAGS  | commit R/CCR, pulse done, back to IDLE

  localparam int NSLICE = OP_SIZE / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FLAGS} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [OP_SIZE-1:0] a_sh, b_sh, res_sh;
  logic [2:0]         op_q;
  logic               carry;
  logic               nz_acc;
  logic               a_msb, b_msb;

  logic               accept;
  logic               last_slice;
  logic               is_sub, is_logic;
  logic [SLICE-1:0]   a_sl, b_sl, slice_res;
  logic [SLICE:0]     sum;
  logic               c_new, v_new, n_new, z_new;

  assign accept     = (state == S_IDLE) && start;
  assign last_slice = (cnt == CW'(NSLICE - 1));
  assign is_sub     = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CMP);
  assign is_logic   = op_q[2] && (op_q[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (last_slice) state_nxt = S_FLAGS;
      S_FLAGS: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Subtraction is A + ~B + carry-in, so the B slice is inverted on the fly
  assign a_sl = a_sh[SLICE-1:0];
  assign b_sl = is_sub ? ~b_sh[SLICE-1:0] : b_sh[SLICE-1:0];
  assign sum  = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry);

  always_comb begin
    slice_res = sum[SLICE-1:0];
`ifdef SEQ_ALU_LOGIC_OPS_EN
    case (op_q)
      3'b101:  slice_res = a_sl & b_sl;
      3'b110:  slice_res = a_sl | b_sl;
      3'b111:  slice_res = a_sl ^ b_sl;
      default: ;
    endcase
`endif
  end

  // Carry out of the last slice is a borrow indicator (inverted) on subtracts
  assign c_new = is_sub ? ~carry : carry;
  assign n_new = res_sh[OP_SIZE-1];
  assign z_new = ~nz_acc;
  assign v_new = is_sub ? ((a_msb != b_msb) && (n_new != a_msb))
                        : ((a_msb == b_msb) && (n_new != a_msb));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= '0;
      carry  <= 1'b0;
      nz_acc <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      a_sh   <= A;
      b_sh   <= B;
      op_q   <= op;
      nz_acc <= 1'b0;
      a_msb  <= A[OP_SIZE-1];
      b_msb  <= B[OP_SIZE-1];
      case (op)
        OP_ADC:  carry <= CCR[3];
        OP_SUB:  carry <= 1'b1;
        OP_SBC:  carry <= ~CCR[3];
        OP_CMP:  carry <= 1'b1;
        default: carry <= 1'b0;
      endcase
    end else if (state == S_CALC) begin
      cnt    <= cnt + 1'b1;
      a_sh   <= a_sh >> SLICE;
      b_sh   <= b_sh >> SLICE;
      res_sh <= {slice_res, res_sh[OP_SIZE-1:SLICE]};
      carry  <= sum[SLICE];
      nz_acc <= nz_acc | (|slice_res);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R    <= '0;
      CCR  <= 4'b0000;
      done <= 1'b0;
    end else begin
      done <= (state == S_FLAGS);
      if (state == S_FLAGS) begin
        if (!is_logic) begin
          if (op_q != OP_CMP) R <= res_sh;
          CCR <= {c_new, v_new, n_new, z_new};
        end
`ifdef SEQ_ALU_LOGIC_OPS_EN
        else begin
          R   <= res_sh;
          CCR <= {CCR[3], 1'b0, n_new, z_new};
        end
`endif
      end
    end
  end

  assign busy = (state != S_IDLE) || done;

endmodule
